// File: rtl/four_bit_parallel_adder.sv
// Registered 4-bit ripple-carry adder from four full-adder cells; 1-cycle latency.
// Define FOUR_BIT_PARALLEL_ADDER_OVF_EN to add the registered signed-overflow output ovf.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic k_in,
  output logic s,
  output logic k_out
);

  assign s     = a ^ b ^ k_in;
  assign k_out = (a & b) | (k_in & (a ^ b));

endmodule

module four_bit_parallel_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic [3:1] c,
  output logic       cout,
  output logic       out_valid
`ifdef FOUR_BIT_PARALLEL_ADDER_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam int unsigned W = 4;

  logic [W:0]   k;
  logic [W-1:0] sum;

  assign k[0] = cin;

  // Pure ripple chain: k[i+1] feeds only from cell i.
  for (genvar i = 0; i < W; i++) begin : g_cell
    full_adder_cell u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .k_in  (k[i]),
      .s     (sum[i]),
      .k_out (k[i+1])
    );
  end

  // Result registers load only on in_valid, so undriven inputs cannot disturb held values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      c         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        c    <= k[W-1:1];
        cout <= k[W];
      end
    end
  end

`ifdef FOUR_BIT_PARALLEL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= k[W-1] ^ k[W];
    end
  end
`endif

endmodule

// File: tb/tb_four_bit_parallel_adder.sv
// Directed and exhaustive checks of four_bit_parallel_adder against hand-computed results.
// Honors FOUR_BIT_PARALLEL_ADDER_OVF_EN to also check ovf.

module tb_four_bit_parallel_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic [3:1] c;
  logic       cout;
  logic       out_valid;
`ifdef FOUR_BIT_PARALLEL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  four_bit_parallel_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .c         (c),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef FOUR_BIT_PARALLEL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all result outputs; expected ovf follows from operand and sum sign bits.
  task automatic check_out(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [3:0] es, input logic [2:0] ec, input logic ecout,
                           input logic evalid);
    check({tag, ".s"},         8'(s),         8'(es));
    check({tag, ".c"},         8'(c),         8'(ec));
    check({tag, ".cout"},      8'(cout),      8'(ecout));
    check({tag, ".out_valid"}, 8'(out_valid), 8'(evalid));
`ifdef FOUR_BIT_PARALLEL_ADDER_OVF_EN
    check({tag, ".ovf"}, 8'(ovf), 8'((ea[3] == eb[3]) && (es[3] != ea[3])));
`endif
  endtask

  task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic vcin, input logic [3:0] es, input logic [2:0] ec,
                       input logic ecout);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    tick();
    check_out(tag, va, vb, es, ec, ecout, 1'b1);
  endtask

  // Carry into bit i derived arithmetically from the low i bits of the operands.
  function automatic logic [2:0] exp_carries(input logic [3:0] xa, input logic [3:0] xb,
                                             input logic xc);
    logic [2:0] r;
    for (int i = 1; i <= 3; i++) begin
      logic [4:0] m;
      logic [4:0] t;
      m = 5'((1 << i) - 1);
      t = (5'(xa) & m) + (5'(xb) & m) + 5'(xc);
      r[i-1] = t[i];
    end
    return r;
  endfunction

  initial begin
    logic [3:0] pa, pb;
    logic       pc;
    logic [4:0] tot;

    rst = 1'b1; in_valid = 1'b1; a = 4'h7; b = 4'h7; cin = 1'b0;
    pa = '0; pb = '0; pc = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      check_out("reset", 4'h0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0);
    end

    rst = 1'b0;
    apply("zero",    4'h0, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0);
    apply("5pA1",    4'h5, 4'hA, 1'b1, 4'h0, 3'b111, 1'b1);
    apply("Fp1",     4'hF, 4'h1, 1'b0, 4'h0, 3'b111, 1'b1);
    apply("7p1",     4'h7, 4'h1, 1'b0, 4'h8, 3'b111, 1'b0);
    apply("8p8",     4'h8, 4'h8, 1'b0, 4'h0, 3'b000, 1'b1);
    apply("3p4",     4'h3, 4'h4, 1'b0, 4'h7, 3'b000, 1'b0);

    in_valid = 1'b0; a = 4'hF; b = 4'hF; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("hold", 4'h3, 4'h4, 4'h7, 3'b000, 1'b0, 1'b0);
    end
    a = 'x; b = 'x; cin = 'x;
    tick();
    check_out("hold_x", 4'h3, 4'h4, 4'h7, 3'b000, 1'b0, 1'b0);

    // Reset overrides a valid input in the same cycle.
    rst = 1'b1; in_valid = 1'b1; a = 4'h2; b = 4'h3; cin = 1'b0;
    tick();
    check_out("rst_mid", 4'h0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check_out("post_rst", 4'h0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0);
    apply("6p6", 4'h6, 4'h6, 1'b1, 4'hD, 3'b110, 1'b0);

    // Exhaustive back-to-back sweep: each cycle checks the previous cycle's operands.
    for (int i = 0; i <= 512; i++) begin
      if (i < 512) begin
        logic [8:0] v;
        v = 9'(i);
        a = v[8:5]; b = v[4:1]; cin = v[0]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i < 512) begin
        pa = a; pb = b; pc = cin;
        tot = 5'(pa) + 5'(pb) + 5'(pc);
        check_out("sweep", pa, pb, tot[3:0], exp_carries(pa, pb, pc), tot[4], 1'b1);
      end
    end
    tot = 5'(pa) + 5'(pb) + 5'(pc);
    check_out("sweep_end", pa, pb, tot[3:0], exp_carries(pa, pb, pc), tot[4], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
